// File: rtl/frame_window_display.sv
// frame_window_display
// Display-side reader for a grey image held in a frame RAM. Places the image
// at (X0,Y0) on the VGA raster with integer pixel replication, generates RAM
// read addresses using counters only, delays the syncs to line up with the
// RAM read latency, and maps each pixel to RGB under a per-frame colour mode.

module frame_window_display #(
    parameter int IMG_W     = 250,
    parameter int IMG_H     = 125,
    parameter int X0        = 195,
    parameter int Y0        = 155,
    parameter int SCALE     = 1,
    parameter int COORD_W   = 11,
    parameter int ADDR_W    = 15,
    parameter int PIX_W     = 8,
    parameter int GRAY_BITS = 2,
    parameter int RAM_LAT   = 1,
    parameter logic [3*GRAY_BITS-1:0] BG_COLOR = 6'b101011
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [COORD_W-1:0]       pixel_x,
    input  logic [COORD_W-1:0]       pixel_y,
    input  logic                     videoon,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic [1:0]               mode,
    input  logic [PIX_W-1:0]         threshold,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_rd_en,
    input  logic [PIX_W-1:0]         ram_dout,
    output logic [3*GRAY_BITS-1:0]   rgb,
    output logic                     hsync_out,
    output logic                     vsync_out,
    output logic                     frame_start
);

    // Window bounds are elaboration-time constants, so the run-time test is
    // four magnitude compares and no multiplier.
    localparam logic [COORD_W-1:0] X_LO = COORD_W'(X0);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(X0 + IMG_W * SCALE);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(Y0);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(Y0 + IMG_H * SCALE);

    // Replication counters run 0..SCALE-1; SCALE is at most 4.
    localparam logic [1:0]        REP_MAX  = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    // Sideband stages: the S1 register plus one per RAM latency cycle.
    localparam int DLY = RAM_LAT + 1;

    typedef enum logic [1:0] {
        MODE_GREY   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_GREY_3 = 2'd3
    } colour_mode_t;

    logic                 in_win;
    logic                 at_left;
    logic                 at_top;

    logic [ADDR_W-1:0]    col;
    logic [ADDR_W-1:0]    row_base;
    logic [1:0]           x_rep;
    logic [1:0]           y_rep;

    logic [ADDR_W-1:0]    col_nxt;
    logic [ADDR_W-1:0]    row_base_nxt;
    logic [1:0]           x_rep_nxt;
    logic [1:0]           y_rep_nxt;
    logic [ADDR_W-1:0]    addr_nxt;

    logic [DLY-1:0]       videoon_d;
    logic [DLY-1:0]       in_win_d;
    logic [DLY-1:0]       hsync_d;
    logic [DLY-1:0]       vsync_d;

    colour_mode_t         mode_q;
    logic [PIX_W-1:0]     thr_q;

    logic [GRAY_BITS-1:0] gray_top;
    logic [GRAY_BITS-1:0] gray_level;

    assign in_win  = (pixel_x >= X_LO) && (pixel_x < X_HI) &&
                     (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    assign at_left = (pixel_x == X_LO);
    assign at_top  = (pixel_y == Y_LO);

    // Next column / row position for the current in-window pixel; the row is
    // advanced once per line, at the first window pixel of that line.
    always_comb begin
        col_nxt      = col;
        row_base_nxt = row_base;
        x_rep_nxt    = x_rep;
        y_rep_nxt    = y_rep;
        if (at_left) begin
            col_nxt   = '0;
            x_rep_nxt = '0;
            if (at_top) begin
                row_base_nxt = '0;
                y_rep_nxt    = '0;
            end else if (y_rep == REP_MAX) begin
                row_base_nxt = row_base + ROW_STEP;
                y_rep_nxt    = '0;
            end else begin
                y_rep_nxt = y_rep + 2'd1;
            end
        end else if (x_rep == REP_MAX) begin
            col_nxt   = col + ADDR_W'(1);
            x_rep_nxt = '0;
        end else begin
            x_rep_nxt = x_rep + 2'd1;
        end
        addr_nxt = row_base_nxt + col_nxt;
    end

    // Stage S1: counters and RAM address only move on visible in-window pixels.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col         <= '0;
            row_base    <= '0;
            x_rep       <= '0;
            y_rep       <= '0;
            ram_addr    <= '0;
            ram_rd_en   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (pixel_x == '0) && (pixel_y == '0);
            ram_rd_en   <= in_win && videoon;
            if (in_win && videoon) begin
                col      <= col_nxt;
                row_base <= row_base_nxt;
                x_rep    <= x_rep_nxt;
                y_rep    <= y_rep_nxt;
                ram_addr <= addr_nxt;
            end
        end
    end

    // Sideband delay lines; syncs idle high so outputs stay inactive after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            videoon_d <= '0;
            in_win_d  <= '0;
            hsync_d   <= '1;
            vsync_d   <= '1;
        end else begin
            videoon_d <= {videoon_d[DLY-2:0], videoon};
            in_win_d  <= {in_win_d[DLY-2:0], in_win};
            hsync_d   <= {hsync_d[DLY-2:0], hsync_in};
            vsync_d   <= {vsync_d[DLY-2:0], vsync_in};
        end
    end

    // Colour mode and threshold only change at frame start so a frame never tears.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q <= MODE_GREY;
            thr_q  <= '0;
        end else if (frame_start) begin
            mode_q <= colour_mode_t'(mode);
            thr_q  <= threshold;
        end
    end

    assign gray_top = ram_dout[PIX_W-1 -: GRAY_BITS];

    // Grey level for one channel under the latched colour mode.
    always_comb begin
        gray_level = gray_top;
        case (mode_q)
            MODE_INVERT: gray_level = ~gray_top;
            MODE_THRESH: gray_level = (ram_dout >= thr_q) ? '1 : '0;
            default:     gray_level = gray_top;
        endcase
    end

    // Output stage: colour and syncs leave together, RAM_LAT+2 cycles after input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            hsync_out <= hsync_d[DLY-1];
            vsync_out <= vsync_d[DLY-1];
            if (!videoon_d[DLY-1]) begin
                rgb <= '0;
            end else if (!in_win_d[DLY-1]) begin
                rgb <= BG_COLOR;
            end else begin
                rgb <= {3{gray_level}};
            end
        end
    end

endmodule

// File: tb/tb_frame_window_display.sv
// tb_frame_window_display
// Self-checking bench: table of single-pixel colour vectors, hand-written
// reset and mode-latch sequences, and one randomised raster frame checked
// against an arithmetic reference model of the window and colour mapping.

module tb_frame_window_display;

    localparam int IMG_W = 250;
    localparam int IMG_H = 125;
    localparam int X0    = 195;
    localparam int Y0    = 155;
    localparam int X_END = X0 + IMG_W;
    localparam int Y_END = Y0 + IMG_H;
    localparam int BG    = 43;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        videoon;
    logic        hsync_in;
    logic        vsync_in;
    logic [1:0]  mode;
    logic [7:0]  threshold;

    logic [14:0] ram_addr,  ram_addr2;
    logic        ram_rd_en, ram_rd_en2;
    logic [7:0]  ram_dout,  ram_dout2;
    logic [5:0]  rgb,       rgb2;
    logic        hsync_out, hsync_out2;
    logic        vsync_out, vsync_out2;
    logic        frame_start, frame_start2;

    logic [7:0]  mem [0:32767];
    logic        fixed_en;
    logic [7:0]  fixed_val;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string name;
        int    x;
        int    y;
        bit    vo;
        int    md;
        int    thr;
        int    dout;
        int    exp_rgb;
    } vec_t;

    typedef struct {
        int rgb;
        int hs;
        int vs;
    } exp_t;

    vec_t vecs [14];
    exp_t exp_q [$];

    frame_window_display u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .videoon     (videoon),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .mode        (mode),
        .threshold   (threshold),
        .ram_addr    (ram_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_dout    (ram_dout),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .frame_start (frame_start)
    );

    frame_window_display #(.SCALE(2)) u_dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .videoon     (videoon),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .mode        (mode),
        .threshold   (threshold),
        .ram_addr    (ram_addr2),
        .ram_rd_en   (ram_rd_en2),
        .ram_dout    (ram_dout2),
        .rgb         (rgb2),
        .hsync_out   (hsync_out2),
        .vsync_out   (vsync_out2),
        .frame_start (frame_start2)
    );

    // Pixel clock.
    always #5 clk = ~clk;

    // Frame RAM with one cycle of read latency; can be forced to a fixed word.
    always @(posedge clk) begin
        ram_dout  <= fixed_en ? fixed_val : mem[ram_addr];
        ram_dout2 <= mem[ram_addr2];
    end

    function automatic bit ref_in_win(int x, int y, int s);
        return (x >= X0) && (x < X0 + IMG_W * s) && (y >= Y0) && (y < Y0 + IMG_H * s);
    endfunction

    function automatic int ref_addr(int x, int y, int s);
        return ((y - Y0) / s) * IMG_W + (x - X0) / s;
    endfunction

    // Colour of one screen pixel: level 0..3 per channel, all three channels equal.
    function automatic int ref_colour(int x, int y, bit vo, int dout, int md, int thr);
        int level;
        if (!vo) return 0;
        if (!ref_in_win(x, y, 1)) return BG;
        case (md)
            1:       level = 3 - dout / 64;
            2:       level = (dout >= thr) ? 3 : 0;
            default: level = dout / 64;
        endcase
        return level * 21;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (px=%0d py=%0d t=%0t)",
                     name, actual, expected, pixel_x, pixel_y, $time);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input bit vo, input bit hs, input bit vs);
        pixel_x  = 11'(x);
        pixel_y  = 11'(y);
        videoon  = vo;
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic framePulse();
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
        checkOutput("frame_start_pulse", int'(frame_start), 1);
        applyStimulus(1, 0, 1'b0, 1'b1, 1'b1);
        checkOutput("frame_start_drop", int'(frame_start), 0);
    endtask

    // Present one pixel, then two idle cycles; rgb for it is visible afterwards.
    task automatic pixelThrough(input int x, input int y, input bit vo);
        applyStimulus(x, y, vo, 1'b1, 1'b1);
        applyStimulus(1, 1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        exp_t e;
        exp_t got;
        int   fmode;
        int   fthr;
        bit   vo;
        bit   hs;
        bit   vs;
        bit   win;
        int   dout;

        vecs[0]  = '{"grey_C3",     195, 155, 1'b1, 0, 0,   8'hC3, 63};
        vecs[1]  = '{"invert_C3",   195, 155, 1'b1, 1, 0,   8'hC3, 0};
        vecs[2]  = '{"thr_below",   195, 155, 1'b1, 2, 196, 8'hC3, 0};
        vecs[3]  = '{"thr_equal",   195, 155, 1'b1, 2, 196, 8'hC4, 63};
        vecs[4]  = '{"mode3_C3",    195, 155, 1'b1, 3, 0,   8'hC3, 63};
        vecs[5]  = '{"grey_43",     195, 155, 1'b1, 0, 0,   8'h43, 21};
        vecs[6]  = '{"invert_43",   195, 155, 1'b1, 1, 0,   8'h43, 42};
        vecs[7]  = '{"bg_left",     194, 155, 1'b1, 0, 0,   8'hC3, BG};
        vecs[8]  = '{"bg_right",    445, 155, 1'b1, 0, 0,   8'hC3, BG};
        vecs[9]  = '{"bg_above",    200, 154, 1'b1, 0, 0,   8'hC3, BG};
        vecs[10] = '{"bg_below",    200, 280, 1'b1, 0, 0,   8'hC3, BG};
        vecs[11] = '{"blank",       200, 160, 1'b0, 0, 0,   8'hC3, 0};
        vecs[12] = '{"last_pixel",  444, 279, 1'b1, 0, 0,   8'h80, 42};
        vecs[13] = '{"thr_above",   195, 155, 1'b1, 2, 16,  8'hFF, 63};

        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom_range(0, 255));

        reset_n   = 1'b0;
        mode      = 2'd0;
        threshold = 8'd0;
        fixed_en  = 1'b1;
        fixed_val = 8'hC3;

        // Reset state.
        applyStimulus(1, 1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1, 1, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_rgb",         int'(rgb),         0);
        checkOutput("reset_hsync",       int'(hsync_out),   1);
        checkOutput("reset_vsync",       int'(vsync_out),   1);
        checkOutput("reset_addr",        int'(ram_addr),    0);
        checkOutput("reset_rd_en",       int'(ram_rd_en),   0);
        checkOutput("reset_frame_start", int'(frame_start), 0);
        reset_n = 1'b1;

        // Table of single-pixel colour vectors, each with its own frame start.
        for (int i = 0; i < 14; i++) begin
            mode      = 2'(vecs[i].md);
            threshold = 8'(vecs[i].thr);
            fixed_val = 8'(vecs[i].dout);
            framePulse();
            pixelThrough(vecs[i].x, vecs[i].y, vecs[i].vo);
            checkOutput(vecs[i].name, int'(rgb), vecs[i].exp_rgb);
        end

        // Mode changes mid-frame must wait for the next frame start.
        mode      = 2'd0;
        fixed_val = 8'hC3;
        framePulse();
        mode = 2'd1;
        pixelThrough(195, 155, 1'b1);
        checkOutput("mode_no_tear", int'(rgb), 63);
        framePulse();
        pixelThrough(195, 155, 1'b1);
        checkOutput("mode_after_frame_start", int'(rgb), 0);

        // Reset in the middle of a visible line.
        for (int x = 195; x <= 200; x++) applyStimulus(x, 155, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        applyStimulus(201, 155, 1'b1, 1'b0, 1'b0);
        checkOutput("midline_reset_rgb",   int'(rgb),       0);
        checkOutput("midline_reset_hsync", int'(hsync_out), 1);
        checkOutput("midline_reset_vsync", int'(vsync_out), 1);
        checkOutput("midline_reset_addr",  int'(ram_addr),  0);
        checkOutput("midline_reset_rd_en", int'(ram_rd_en), 0);
        reset_n = 1'b1;
        applyStimulus(202, 155, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_hsync_1", int'(hsync_out), 1);
        applyStimulus(203, 155, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_hsync_2", int'(hsync_out), 1);
        applyStimulus(204, 155, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_hsync_3", int'(hsync_out), 0);
        checkOutput("post_reset_mode_grey", int'(rgb), 63);

        // Randomised raster frame against the reference model.
        reset_n = 1'b0;
        applyStimulus(1, 1, 1'b0, 1'b1, 1'b1);
        reset_n  = 1'b1;
        fixed_en = 1'b0;
        exp_q.delete();
        e = '{0, 1, 1};
        exp_q.push_back(e);
        exp_q.push_back(e);

        fmode     = int'($urandom_range(0, 3));
        fthr      = int'($urandom_range(0, 255));
        mode      = 2'(fmode);
        threshold = 8'(fthr);
        for (int x = 0; x < 2; x++) begin
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            applyStimulus(x, 0, 1'b0, hs, vs);
            e = '{0, int'(hs), int'(vs)};
            exp_q.push_back(e);
            got = exp_q.pop_front();
            checkOutput("raster_rgb",   int'(rgb),       got.rgb);
            checkOutput("raster_hsync", int'(hsync_out), got.hs);
            checkOutput("raster_vsync", int'(vsync_out), got.vs);
        end

        for (int y = Y0 - 2; y <= Y_END + 1; y++) begin
            for (int x = X0 - 3; x <= X_END + 2; x++) begin
                win       = ref_in_win(x, y, 1);
                vo        = win ? 1'b1 : 1'($urandom_range(0, 1));
                hs        = 1'($urandom_range(0, 1));
                vs        = 1'($urandom_range(0, 1));
                mode      = 2'($urandom_range(0, 3));
                threshold = 8'($urandom_range(0, 255));
                applyStimulus(x, y, vo, hs, vs);

                dout = win ? int'(mem[ref_addr(x, y, 1)]) : 0;
                e = '{ref_colour(x, y, vo, dout, fmode, fthr), int'(hs), int'(vs)};
                exp_q.push_back(e);
                got = exp_q.pop_front();
                checkOutput("raster_rgb",   int'(rgb),       got.rgb);
                checkOutput("raster_hsync", int'(hsync_out), got.hs);
                checkOutput("raster_vsync", int'(vsync_out), got.vs);
                checkOutput("raster_rd_en", int'(ram_rd_en), int'(win && vo));
                if (win) checkOutput("raster_addr", int'(ram_addr), ref_addr(x, y, 1));

                if (x <= X_END - 1 && y <= Y_END - 1 && ref_in_win(x, y, 2))
                    checkOutput("scale2_addr", int'(ram_addr2), ref_addr(x, y, 2));

                if (x == 195 && y == 155) checkOutput("spot_first",     int'(ram_addr), 0);
                if (x == 444 && y == 155) checkOutput("spot_row0_end",  int'(ram_addr), 249);
                if (x == 195 && y == 156) checkOutput("spot_row1",      int'(ram_addr), 250);
                if (x == 444 && y == 279) checkOutput("spot_last",      int'(ram_addr), 31249);
                if (x == 196 && y == 155) checkOutput("s2_x196",        int'(ram_addr2), 0);
                if (x == 197 && y == 155) checkOutput("s2_x197",        int'(ram_addr2), 1);
                if (x == 195 && y == 156) checkOutput("s2_line156",     int'(ram_addr2), 0);
                if (x == 195 && y == 157) checkOutput("s2_line157",     int'(ram_addr2), 250);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
